// File: rtl/mips_ctrl_defs.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, functs, FSM states
// and datapath select codes. The instruction classifier and the sequencer both import this.
package mips_ctrl_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_SLT = 3'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_JUMP   = 2'd1,
        PC_RS     = 2'd2,
        PC_BRANCH = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } reg_dst_t;

    typedef enum logic [1:0] {
        DIN_ALU = 2'd0,
        DIN_MEM = 2'd1,
        DIN_PC4 = 2'd2
    } reg_din_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_ADD,
        CLS_SUB,
        CLS_SLT,
        CLS_ADDI,
        CLS_XORI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE
    } instr_class_t;

    function automatic alu_op_t class_alu_op(input instr_class_t cls);
        case (cls)
            CLS_SUB, CLS_BEQ, CLS_BNE: return ALU_SUB;
            CLS_XORI:                  return ALU_XOR;
            CLS_SLT:                   return ALU_SLT;
            default:                   return ALU_ADD;
        endcase
    endfunction

    function automatic logic class_uses_imm(input instr_class_t cls);
        return (cls == CLS_ADDI) || (cls == CLS_XORI) || (cls == CLS_LW) || (cls == CLS_SW);
    endfunction

    function automatic logic class_is_rtype_alu(input instr_class_t cls);
        return (cls == CLS_ADD) || (cls == CLS_SUB) || (cls == CLS_SLT);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath/memory bundle: IR fields and memory handshakes in, strobes and selects out.
// master = sequencer side, slave = datapath/memory side.
interface mc_control_fsm_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        im_ready;
    logic        dm_ready;
    logic        im_req;
    logic        dm_req;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        reg_we;
    logic [1:0]  reg_dst_ctrl;
    logic [1:0]  reg_din_ctrl;
    logic        dm_we;
    logic [2:0]  alu_op;
    logic        alu_b_src;
    logic        illegal;
    logic [2:0]  state_dbg;
    logic [31:0] instret;

    modport master (
        input  opcode, funct, alu_zero, im_ready, dm_ready,
        output im_req, dm_req, ir_we, pc_we, pc_src, reg_we, reg_dst_ctrl, reg_din_ctrl,
               dm_we, alu_op, alu_b_src, illegal, state_dbg, instret
    );

    modport slave (
        output opcode, funct, alu_zero, im_ready, dm_ready,
        input  im_req, dm_req, ir_we, pc_we, pc_src, reg_we, reg_dst_ctrl, reg_din_ctrl,
               dm_we, alu_op, alu_b_src, illegal, state_dbg, instret
    );
endinterface

// File: rtl/mc_instr_class.sv
// Combinational opcode/funct classifier; zero latency, no handshake.
module mc_instr_class
    import mips_ctrl_defs::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic         illegal
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_JR:   cls = CLS_JR;
                    FN_ADD:  cls = CLS_ADD;
                    FN_SUB:  cls = CLS_SUB;
                    FN_SLT:  cls = CLS_SLT;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            OP_BEQ:  cls = CLS_BEQ;
            OP_BNE:  cls = CLS_BNE;
            OP_ADDI: cls = CLS_ADDI;
            OP_XORI: cls = CLS_XORI;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            default: cls = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; 2-5 cycles per instruction, +1 per im_ready/dm_ready wait.
// MC_PERF_COUNT_EN builds the instret counter; otherwise instret is tied to zero.
module mc_control_fsm
    import mips_ctrl_defs::*;
#(
    parameter int RA_REG    = 31,
    parameter bit TRAP_HOLD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    mc_control_fsm_if.master  bus
);

    // The datapath's write-port mux resolves DST_RA to this register index.
    localparam int unused_ra_reg = RA_REG;

    state_t       state;
    state_t       state_nxt;
    instr_class_t cls;
    logic         cls_illegal;
    alu_op_t      ex_alu_op;
    logic         ex_imm;

    logic         im_req_c;
    logic         dm_req_c;
    logic         ir_we_c;
    logic         pc_we_c;
    pc_src_t      pc_src_c;
    logic         reg_we_c;
    reg_dst_t     reg_dst_c;
    reg_din_t     reg_din_c;
    logic         dm_we_c;
    alu_op_t      alu_op_c;
    logic         alu_b_src_c;
    logic         illegal_c;
    logic         retire;

    mc_instr_class u_class (
        .opcode  (bus.opcode),
        .funct   (bus.funct),
        .cls     (cls),
        .illegal (cls_illegal)
    );

    assign ex_alu_op = class_alu_op(cls);
    assign ex_imm    = class_uses_imm(cls);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        im_req_c    = 1'b0;
        dm_req_c    = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_src_c    = PC_PLUS4;
        reg_we_c    = 1'b0;
        reg_dst_c   = DST_RT;
        reg_din_c   = DIN_ALU;
        dm_we_c     = 1'b0;
        alu_op_c    = ALU_ADD;
        alu_b_src_c = 1'b0;
        illegal_c   = 1'b0;
        retire      = 1'b0;

        case (state)
            ST_FETCH: begin
                im_req_c = 1'b1;
                if (bus.im_ready) begin
                    ir_we_c   = 1'b1;
                    pc_we_c   = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (cls)
                    CLS_J: begin
                        pc_we_c   = 1'b1;
                        pc_src_c  = PC_JUMP;
                        state_nxt = ST_FETCH;
                        retire    = 1'b1;
                    end
                    CLS_JAL: begin
                        // PC already advanced in FETCH, so PC+4 is the link value.
                        pc_we_c   = 1'b1;
                        pc_src_c  = PC_JUMP;
                        reg_we_c  = 1'b1;
                        reg_dst_c = DST_RA;
                        reg_din_c = DIN_PC4;
                        state_nxt = ST_FETCH;
                        retire    = 1'b1;
                    end
                    CLS_JR: begin
                        pc_we_c   = 1'b1;
                        pc_src_c  = PC_RS;
                        state_nxt = ST_FETCH;
                        retire    = 1'b1;
                    end
                    default: state_nxt = cls_illegal ? ST_TRAP : ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                alu_op_c    = ex_alu_op;
                alu_b_src_c = ex_imm;
                case (cls)
                    CLS_BEQ, CLS_BNE: begin
                        pc_we_c   = (cls == CLS_BEQ) ? bus.alu_zero : ~bus.alu_zero;
                        pc_src_c  = PC_BRANCH;
                        state_nxt = ST_FETCH;
                        retire    = 1'b1;
                    end
                    CLS_LW, CLS_SW: state_nxt = ST_MEM;
                    default:        state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                // ALU keeps computing the effective address for the whole access.
                dm_req_c    = 1'b1;
                dm_we_c     = (cls == CLS_SW);
                alu_op_c    = ex_alu_op;
                alu_b_src_c = ex_imm;
                if (bus.dm_ready) begin
                    if (cls == CLS_SW) begin
                        state_nxt = ST_FETCH;
                        retire    = 1'b1;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we_c    = 1'b1;
                reg_dst_c   = class_is_rtype_alu(cls) ? DST_RD : DST_RT;
                reg_din_c   = (cls == CLS_LW) ? DIN_MEM : DIN_ALU;
                alu_op_c    = ex_alu_op;
                alu_b_src_c = ex_imm;
                state_nxt   = ST_FETCH;
                retire      = 1'b1;
            end
            ST_TRAP: begin
                illegal_c = 1'b1;
                if (!TRAP_HOLD) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    // Requests follow the registered state and drop one cycle after reset is sampled;
    // write strobes and selects are forced quiet while reset is asserted.
    assign bus.im_req       = im_req_c;
    assign bus.dm_req       = dm_req_c;
    assign bus.ir_we        = ir_we_c & ~reset;
    assign bus.pc_we        = pc_we_c & ~reset;
    assign bus.pc_src       = reset ? 2'd0 : pc_src_c;
    assign bus.reg_we       = reg_we_c & ~reset;
    assign bus.reg_dst_ctrl = reset ? 2'd0 : reg_dst_c;
    assign bus.reg_din_ctrl = reset ? 2'd0 : reg_din_c;
    assign bus.dm_we        = dm_we_c & ~reset;
    assign bus.alu_op       = reset ? 3'd0 : alu_op_c;
    assign bus.alu_b_src    = alu_b_src_c & ~reset;
    assign bus.illegal      = illegal_c & ~reset;
    assign bus.state_dbg    = state;

`ifdef MC_PERF_COUNT_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= 32'd0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign bus.instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign bus.instret   = 32'd0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboarded bench for mc_control_fsm: per-instruction expectations from an ISA-level model,
// compared by a monitor when each instruction retires back to FETCH.
module tb_mc_control_fsm;

    typedef struct {
        int cycles;
        int reg_we_n;
        int dst;
        int din;
        int pc_wr;
        int pc_src;
        int dm_cyc;
        int dm_we;
        int alu_op;
        int alu_b;
        int drift;
        int both;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_control_fsm_if bus ();

    mc_control_fsm #(.RA_REG(31), .TRAP_HOLD(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t exp_q[$];
    rec_t cur;
    rec_t e;
    bit   mon_en  = 1'b0;
    int   prev_st = 0;
    int   ret_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // ISA-level expectation: cycle cost and the visible side effects of one instruction.
    function automatic rec_t model(input logic [5:0] op, input logic [5:0] fn, input bit zero,
                                   input int fw, input int mw);
        rec_t r = '{default: 0};
        case (op)
            6'h02: begin r.cycles = 2; r.pc_wr = 1; r.pc_src = 1; end
            6'h03: begin r.cycles = 2; r.pc_wr = 1; r.pc_src = 1; r.reg_we_n = 1; r.dst = 2; r.din = 2; end
            6'h00: begin
                if (fn == 6'h08) begin
                    r.cycles = 2; r.pc_wr = 1; r.pc_src = 2;
                end else begin
                    r.cycles = 4; r.reg_we_n = 1; r.dst = 1;
                    r.alu_op = (fn == 6'h22) ? 1 : (fn == 6'h2a) ? 3 : 0;
                end
            end
            6'h08: begin r.cycles = 4; r.reg_we_n = 1; r.alu_b = 1; end
            6'h0e: begin r.cycles = 4; r.reg_we_n = 1; r.alu_b = 1; r.alu_op = 2; end
            6'h23: begin r.cycles = 5 + mw; r.reg_we_n = 1; r.din = 1; r.dm_cyc = 1 + mw; r.alu_b = 1; end
            6'h2b: begin r.cycles = 4 + mw; r.dm_cyc = 1 + mw; r.dm_we = 1; r.alu_b = 1; end
            6'h04: begin r.cycles = 3; r.alu_op = 1; if (zero) begin r.pc_wr = 1; r.pc_src = 3; end end
            6'h05: begin r.cycles = 3; r.alu_op = 1; if (!zero) begin r.pc_wr = 1; r.pc_src = 3; end end
            default: r.cycles = 0;
        endcase
        r.cycles += fw;
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.state_dbg == 3'd0 && prev_st != 0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL retire: instruction retired with nothing pending");
                end else begin
                    e = exp_q.pop_front();
                    ret_cnt++;
                    chk("cycles",    cur.cycles,   e.cycles);
                    chk("reg_we_n",  cur.reg_we_n, e.reg_we_n);
                    chk("reg_dst",   cur.dst,      e.dst);
                    chk("reg_din",   cur.din,      e.din);
                    chk("pc_wr",     cur.pc_wr,    e.pc_wr);
                    chk("pc_src",    cur.pc_src,   e.pc_src);
                    chk("dm_cycles", cur.dm_cyc,   e.dm_cyc);
                    chk("dm_we",     cur.dm_we,    e.dm_we);
                    chk("alu_op",    cur.alu_op,   e.alu_op);
                    chk("alu_b_src", cur.alu_b,    e.alu_b);
                    chk("mem_drift", cur.drift,    e.drift);
                    chk("req_both",  cur.both,     e.both);
`ifdef MC_PERF_COUNT_EN
                    chk("instret",   bus.instret,  ret_cnt);
`else
                    chk("instret",   bus.instret,  32'd0);
`endif
                end
                cur = '{default: 0};
            end
            cur.cycles++;
            if (bus.reg_we) begin
                cur.reg_we_n++;
                cur.dst = int'(bus.reg_dst_ctrl);
                cur.din = int'(bus.reg_din_ctrl);
            end
            if (bus.pc_we && bus.pc_src != 2'd0) begin
                cur.pc_wr++;
                cur.pc_src = int'(bus.pc_src);
            end
            if (bus.dm_req) begin
                cur.dm_cyc++;
                if (bus.dm_we) cur.dm_we = 1;
            end
            if (bus.state_dbg == 3'd2) begin
                cur.alu_op = int'(bus.alu_op);
                cur.alu_b  = int'(bus.alu_b_src);
            end
            if (bus.state_dbg == 3'd3 && (int'(bus.alu_op) != cur.alu_op || int'(bus.alu_b_src) != cur.alu_b))
                cur.drift = 1;
            if (bus.im_req && bus.dm_req) cur.both = 1;
            prev_st = int'(bus.state_dbg);
        end
    end

    // Wait (bounded) for a memory request, wiggling the ready inputs of the idle memory meanwhile.
    task automatic wait_req(input bit want_dm);
        int n = 0;
        while ((want_dm ? bus.dm_req : bus.im_req) !== 1'b1) begin
            if (n++ > 40) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout: no %s within 40 cycles", want_dm ? "dm_req" : "im_req");
                return;
            end
            bus.im_ready = 1'($urandom);
            bus.dm_ready = 1'($urandom);
            @(negedge clk);
        end
        bus.im_ready = 1'b0;
        bus.dm_ready = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit zero,
                             input int fw, input int mw);
        exp_q.push_back(model(op, fn, zero, fw, mw));
        wait_req(1'b0);
        repeat (fw) begin
            bus.im_ready = 1'b0;
            bus.dm_ready = 1'($urandom);
            @(negedge clk);
        end
        bus.im_ready = 1'b1;
        bus.dm_ready = 1'($urandom);
        bus.opcode   = op;
        bus.funct    = fn;
        bus.alu_zero = zero;
        @(negedge clk);
        bus.im_ready = 1'b0;
        bus.dm_ready = 1'b0;
        if (op == 6'h23 || op == 6'h2b) begin
            wait_req(1'b1);
            repeat (mw) begin
                bus.im_ready = 1'($urandom);
                bus.dm_ready = 1'b0;
                @(negedge clk);
            end
            bus.im_ready = 1'($urandom);
            bus.dm_ready = 1'b1;
            @(negedge clk);
            bus.dm_ready = 1'b0;
            bus.im_ready = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] op_tab [12];
        logic [5:0] fn_tab [12];
        logic [5:0] r_op;
        logic [5:0] r_fn;
        int k;
        int n;

        op_tab = '{6'h02, 6'h03, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0e, 6'h23, 6'h2b, 6'h04, 6'h05};
        fn_tab = '{6'h00, 6'h00, 6'h08, 6'h20, 6'h22, 6'h2a, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

        reset = 1'b1;
        bus.opcode = 6'h00; bus.funct = 6'h00; bus.alu_zero = 1'b0;
        bus.im_ready = 1'b0; bus.dm_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_dm_req", bus.dm_req, 1'b0);
        chk("rst_ir_we",  bus.ir_we,  1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_state",   bus.state_dbg, 3'd0);
        chk("rst_im_req",  bus.im_req,    1'b1);
        chk("rst_dm_req2", bus.dm_req,    1'b0);
        chk("rst_pc_src",  bus.pc_src,    2'd0);
        chk("rst_alu_op",  bus.alu_op,    3'd0);
        chk("rst_illegal", bus.illegal,   1'b0);
        chk("rst_reg_we",  bus.reg_we,    1'b0);
        chk("rst_instret", bus.instret,   32'd0);

        @(posedge clk);
        cur = '{default: 0};
        prev_st = 0;
        mon_en = 1'b1;
        @(negedge clk);

        run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // ADD
        run_instr(6'h23, 6'h11, 1'b0, 0, 2);   // LW, two dm wait cycles
        run_instr(6'h2b, 6'h00, 1'b0, 0, 0);   // SW
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // BEQ taken
        run_instr(6'h05, 6'h00, 1'b1, 0, 0);   // BNE not taken
        run_instr(6'h03, 6'h00, 1'b0, 0, 0);   // JAL
        run_instr(6'h00, 6'h08, 1'b0, 1, 0);   // JR
        for (int i = 0; i < 60; i++) begin
            k    = $urandom_range(0, 11);
            r_op = op_tab[k];
            r_fn = (r_op == 6'h00) ? fn_tab[k] : 6'($urandom);
            run_instr(r_op, r_fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d instructions never retired", exp_q.size());
        end
        mon_en = 1'b0;

        // Reset while an SW is stalled in MEM.
        wait_req(1'b0);
        bus.im_ready = 1'b1; bus.opcode = 6'h2b; bus.funct = 6'h00;
        @(negedge clk);
        bus.im_ready = 1'b0;
        wait_req(1'b1);
        @(negedge clk);
        chk("sw_stall_dm_req", bus.dm_req, 1'b1);
        reset = 1'b1;
        bus.im_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_dm_req", bus.dm_req, 1'b0);
        chk("rst_mid_ir_we",  bus.ir_we,  1'b0);
        chk("rst_mid_pc_we",  bus.pc_we,  1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus.im_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_dm_req",  bus.dm_req,    1'b0);
        chk("post_rst_state",   bus.state_dbg, 3'd0);
        chk("post_rst_instret", bus.instret,   32'd0);
        chk("post_rst_im_req",  bus.im_req,    1'b1);

        // Unsupported opcode traps and sticks until reset.
        bus.im_ready = 1'b1; bus.opcode = 6'h3f; bus.funct = 6'($urandom);
        @(negedge clk);
        bus.im_ready = 1'b0;
        chk("decode_illegal", bus.illegal, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            chk("trap_illegal", bus.illegal,   1'b1);
            chk("trap_state",   bus.state_dbg, 3'd5);
            chk("trap_im_req",  bus.im_req,    1'b0);
            chk("trap_instret", bus.instret,   32'd0);
            bus.im_ready = 1'($urandom);
            bus.dm_ready = 1'($urandom);
            @(negedge clk);
        end
        bus.im_ready = 1'b0;
        bus.dm_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("trap_clr_state",   bus.state_dbg, 3'd0);
        chk("trap_clr_illegal", bus.illegal,   1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control sequencer for the MIPS-subset datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath strobes and the ALU/mux selects; the instruction decoder supplies the opcode and funct fields.
- Handshakes with variable-latency instruction and data memories; traps on unsupported encodings.

Parameters:
- RA_REG, 31, register index written by JAL (drives reg_dst_ctrl=2 meaning).
- TRAP_HOLD, 1, 1 = trap state is sticky until reset; 0 = trap for one cycle then FETCH.

Ports:
- clk input 1 system clock, rising edge
- reset input 1 synchronous active-high reset
- opcode input 6 instr[31:26], from IR
- funct input 6 instr[5:0], from IR
- alu_zero input 1 ALU result==0, valid in EXEC
- im_ready input 1 instruction memory data valid
- dm_ready input 1 data memory access complete
- im_req output 1 instruction fetch request
- dm_req output 1 data memory request
- ir_we output 1 latch instruction register
- pc_we output 1 PC write enable
- pc_src output 2 0=PC+4, 1=jump target, 2=rs (JR), 3=branch target
- reg_we output 1 register file write enable
- reg_dst_ctrl output 2 0=rt, 1=rd, 2=RA_REG
- reg_din_ctrl output 2 0=ALU, 1=data memory, 2=PC+4
- dm_we output 1 data memory write (qualifies dm_req)
- alu_op output 3 0=add, 1=sub, 2=xor, 3=slt
- alu_b_src output 1 0=rt, 1=sign/zero-extended imm
- illegal output 1 unsupported instruction trapped
- state_dbg output 3 current state encoding
- instret output 32 retired-instruction count (see Optional Feature)

Behaviour:
- States, encoded 0..5: FETCH, DECODE, EXEC, MEM, WB, TRAP. All outputs are decoded from the registered state and the registered opcode/funct; outputs are registered-state Moore, not comb-through from inputs except where noted.
- reset=1 at an edge: state←FETCH, instret←0. reset dominates any in-flight request: im_req/dm_req drop the cycle after reset is sampled. Outputs during and right after reset: all strobes 0, pc_src=0, alu_op=0, illegal=0.
- FETCH:
  - im_req=1, held until im_ready.
  - On the im_ready cycle: ir_we=1, pc_we=1, pc_src=0 (comb on im_ready); next state DECODE. Otherwise stay in FETCH.
- DECODE: classify the opcode/funct now latched in IR.
  - J(02): pc_we=1, pc_src=1 → FETCH.
  - JAL(03): pc_we=1, pc_src=1, reg_we=1, reg_dst_ctrl=2, reg_din_ctrl=2 (PC already +4) → FETCH.
  - JR(00/08): pc_we=1, pc_src=2 → FETCH.
  - ADD(00/20), SUB(00/22), SLT(00/2a), ADDI(08), XORI(0e), LW(23), SW(2b), BEQ(04), BNE(05) → EXEC.
  - Anything else → TRAP.
- EXEC: alu_op = ADD/ADDI/LW/SW:0, SUB/BEQ/BNE:1, XORI:2, SLT:3. alu_b_src=1 for I-type, 0 for R-type and branches.
  - Branches: pc_we = BEQ ? alu_zero : ~alu_zero (comb), pc_src=3 → FETCH.
  - LW/SW → MEM. ALU ops → WB.
- MEM:
  - dm_req=1; dm_we=1 for SW.
  - Hold until dm_ready. alu_op/alu_b_src are held at EXEC values so the address stays stable.
  - On dm_ready: SW → FETCH, LW → WB.
- WB: reg_we=1 for exactly one cycle → FETCH.
  - reg_dst_ctrl: 1 for R-type, 0 for I-type/LW.
  - reg_din_ctrl: 1 for LW, 0 otherwise.
- TRAP: illegal=1, no strobes. With TRAP_HOLD=1, stays until reset; with 0, → FETCH next cycle.
- Latency with zero-wait memories, in cycles:
  - J/JAL/JR: 2.
  - Branch: 3.
  - ALU: 4.
  - SW: 4.
  - LW: 5.
  - Each extra wait cycle on im_ready/dm_ready adds 1.
- Simultaneity:
  - dm_ready outside MEM and im_ready outside FETCH are ignored.
  - dm_req and im_req are never both high.
- instret increments by 1 on the final cycle of each retired instruction: the transition into FETCH from DECODE/EXEC/MEM/WB. Not incremented from TRAP. Wraps mod 2^32.

Optional Feature:
- MC_PERF_COUNT_EN defined: instret counter implemented as above.
- Undefined: no counter flops; instret tied to 32'd0. All other behaviour is identical.

Decomposition:
- Shared package/include file mips_ctrl_defs holds:
  - Opcode and funct constants.
  - State encodings.
  - alu_op, pc_src, reg_din_ctrl and reg_dst_ctrl codes.
- The existing decoder should migrate to the same file.
- One natural sub-module: mc_instr_class, a combinational opcode/funct → class/illegal decode. The FSM stays in mc_control_fsm.

Test Plan:
- Reset held 2 cycles mid-MEM of an SW → next cycle dm_req=0, state_dbg=0, instret=0, im_req=1.
- ADD (0x00, funct 0x20), im_ready tied 1 → ir_we at cycle 1, alu_op=0/alu_b_src=0 in EXEC, reg_we=1 with reg_dst_ctrl=1 in cycle 4, instret=1.
- LW (0x23), dm_ready delayed 2 cycles → dm_req high 3 cycles, reg_we with reg_din_ctrl=1 at cycle 7; SW (0x2b) → dm_we=1 during MEM, no reg_we, 4 cycles.
- BEQ with alu_zero=1 → pc_we=1, pc_src=3 in EXEC; BNE with alu_zero=1 → pc_we=0; both return to FETCH after 3 cycles.
- JAL (0x03) → DECODE: pc_we=1, pc_src=1, reg_we=1, reg_dst_ctrl=2, reg_din_ctrl=2; JR (0x00/0x08) → pc_src=2.
- Opcode 0x3f → illegal=1, state_dbg=5 held for 20 cycles (TRAP_HOLD=1), instret unchanged; reset clears.
